// File: rtl/eightbit_divider.sv
// -----------------------------------------------------------------------------
// eightbit_divider
//
// Multi-cycle unsigned 8-bit restoring divider. Each RUN cycle shifts the next
// dividend bit into the partial remainder and performs a 9-bit trial
// subtraction of the divisor. If the subtraction borrows, the shifted remainder
// is kept (restored); otherwise the difference is kept. A quotient bit of 1 is
// shifted in when there is no borrow. Eight iterations produce the 8-bit
// quotient and remainder.
//
// A zero divisor never enters RUN. The result (quotient=FF, remainder=dividend,
// div_by_zero=1) is written on the same edge that accepts the start.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset (priority over everything)
//   start        request pulse, honoured only while idle
//   dividend     unsigned numerator, captured with an accepted start
//   divisor      unsigned denominator, captured with an accepted start
//   busy         high while iterating (RUN state)
//   done         one-cycle pulse: quotient/remainder/div_by_zero just updated
//   quotient     result quotient, held until the next completion
//   remainder    result remainder, held until the next completion
//   div_by_zero  status of the last completed operation
// -----------------------------------------------------------------------------
module eightbit_divider (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       div_by_zero
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t     state;
  state_t     state_next;

  logic [8:0] r;
  logic [7:0] q;
  logic [7:0] d;
  logic [2:0] cnt;

  logic       accept;
  logic       accept_zero;
  logic       accept_run;
  logic       last_iter;

  logic [8:0] shifted;
  logic [8:0] trial;
  logic [8:0] r_next;
  logic [7:0] q_next;

  // 9-bit trial subtraction. The partial remainder is always below the divisor,
  // so the shifted value is below 2*d and bit 8 of the difference is exactly
  // the borrow-out of the subtraction.
  function automatic logic [8:0] trial_sub(input logic [8:0] minuend,
                                           input logic [7:0] den);
    return minuend - {1'b0, den};
  endfunction

  // One restoring-division step on the current partial remainder and quotient.
  always_comb begin
    shifted = {r[7:0], q[7]};
    trial   = trial_sub(shifted, d);
    r_next  = shifted;
    q_next  = {q[6:0], 1'b0};
    if (!trial[8]) begin
      r_next = trial;
      q_next = {q[6:0], 1'b1};
    end
  end

  assign accept      = (state == IDLE) && start;
  assign accept_zero = accept && (divisor == 8'd0);
  assign accept_run  = accept && (divisor != 8'd0);
  assign last_iter   = (state == RUN) && (cnt == 3'd7);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (accept_run) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r           <= 9'd0;
      q           <= 8'd0;
      d           <= 8'd0;
      cnt         <= 3'd0;
      done        <= 1'b0;
      quotient    <= 8'd0;
      remainder   <= 8'd0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept_run) begin
        r   <= 9'd0;
        q   <= dividend;
        d   <= divisor;
        cnt <= 3'd0;
      end else if (accept_zero) begin
        quotient    <= 8'hFF;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
        done        <= 1'b1;
      end else if (state == RUN) begin
        r   <= r_next;
        q   <= q_next;
        cnt <= cnt + 3'd1;
        if (last_iter) begin
          // Results come straight from the final step so they land on the
          // same edge that leaves RUN.
          quotient    <= q_next;
          remainder   <= r_next[7:0];
          div_by_zero <= 1'b0;
          done        <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_eightbit_divider.sv
// -----------------------------------------------------------------------------
// tb_eightbit_divider
//
// Scoreboard bench for eightbit_divider. Each accepted start pushes the
// expected result (computed with the simulator's own / and % operators) into a
// queue; each done pulse pops and compares it. Latency and busy duration are
// measured in clock edges after the start edge.
// -----------------------------------------------------------------------------
module tb_eightbit_divider;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  typedef struct packed {
    logic [7:0] quo;
    logic [7:0] rem;
    logic       dbz;
  } result_t;

  result_t exp_q[$];
  int      checks;
  int      errors;

  eightbit_divider dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic result_t model(input logic [7:0] a, input logic [7:0] b);
    result_t res;
    if (b == 8'd0) begin
      res.quo = 8'hFF;
      res.rem = a;
      res.dbz = 1'b1;
    end else begin
      res.quo = 8'(int'(a) / int'(b));
      res.rem = 8'(int'(a) % int'(b));
      res.dbz = 1'b0;
    end
    return res;
  endfunction

  function automatic result_t observed();
    result_t res;
    res.quo = quotient;
    res.rem = remainder;
    res.dbz = div_by_zero;
    return res;
  endfunction

  function automatic result_t pop_expected();
    result_t res;
    res = '0;
    if (exp_q.size() > 0) res = exp_q.pop_front();
    return res;
  endfunction

  // Drive a one-cycle start and record the expected result. Returns #1 after
  // the start edge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    exp_q.push_back(model(a, b));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges until done is seen (bounded) and cycles with busy high.
  task automatic wait_done(output int n, output int busy_n, output bit timed_out);
    n = 0;
    busy_n = 0;
    timed_out = 1'b0;
    while (!done) begin
      if (busy) busy_n++;
      if (n >= 20) begin
        timed_out = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    start    = 1'b1;
    dividend = 8'd37;
    divisor  = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
      errors++;
      $display("FAIL reset_state: got busy=%0b done=%0b q=%0d r=%0d dbz=%0b, expected all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int n, bn;
    bit to;
    result_t e, o;
    issue(8'd200, 8'd7);
    wait_done(n, bn, to);
    checks++;
    if (to || n !== 8) begin
      errors++;
      $display("FAIL basic_latency: got %0d (timeout=%0b), expected 8", n, to);
    end
    checks++;
    if (bn !== 8) begin
      errors++;
      $display("FAIL basic_busy_cycles: got %0d, expected 8", bn);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_at_done: got %0b, expected 0", busy);
    end
    e = pop_expected();
    o = observed();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL basic_result: got q=%0d r=%0d dbz=%0b, expected q=%0d r=%0d dbz=%0b",
               o.quo, o.rem, o.dbz, e.quo, e.rem, e.dbz);
    end
    // Results hold and done drops while idle.
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || observed() !== e) begin
      errors++;
      $display("FAIL basic_hold: got done=%0b q=%0d r=%0d, expected done=0 q=%0d r=%0d",
               done, quotient, remainder, e.quo, e.rem);
    end
  endtask

  task automatic test_boundary();
    logic [7:0] as [5] = '{8'd255, 8'd5, 8'd0, 8'd255, 8'd1};
    logic [7:0] bs [5] = '{8'd1, 8'd9, 8'd3, 8'd255, 8'd255};
    int n, bn;
    bit to;
    result_t e, o;
    for (int i = 0; i < 5; i++) begin
      issue(as[i], bs[i]);
      wait_done(n, bn, to);
      checks++;
      if (to || n !== 8) begin
        errors++;
        $display("FAIL boundary_latency[%0d]: got %0d (timeout=%0b), expected 8", i, n, to);
      end
      e = pop_expected();
      o = observed();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL boundary_result[%0d] %0d/%0d: got q=%0d r=%0d dbz=%0b, expected q=%0d r=%0d dbz=%0b",
                 i, as[i], bs[i], o.quo, o.rem, o.dbz, e.quo, e.rem, e.dbz);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_div_zero();
    int n, bn;
    bit to;
    result_t e, o;
    issue(8'd37, 8'd0);
    wait_done(n, bn, to);
    checks++;
    if (to || n !== 0) begin
      errors++;
      $display("FAIL dbz_latency: got %0d (timeout=%0b), expected 0 edges after start", n, to);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL dbz_busy: got %0b, expected 0", busy);
    end
    e = pop_expected();
    o = observed();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL dbz_result: got q=%0d r=%0d dbz=%0b, expected q=%0d r=%0d dbz=%0b",
               o.quo, o.rem, o.dbz, e.quo, e.rem, e.dbz);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL dbz_after: got done=%0b busy=%0b, expected 0 0", done, busy);
    end
    issue(8'd9, 8'd2);
    wait_done(n, bn, to);
    checks++;
    if (to || n !== 8) begin
      errors++;
      $display("FAIL after_dbz_latency: got %0d (timeout=%0b), expected 8", n, to);
    end
    e = pop_expected();
    o = observed();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL after_dbz_result: got q=%0d r=%0d dbz=%0b, expected q=%0d r=%0d dbz=%0b",
               o.quo, o.rem, o.dbz, e.quo, e.rem, e.dbz);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ignore_and_back_to_back();
    int n, bn;
    bit to;
    result_t e, o;
    issue(8'd100, 8'd10);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    // Start during iteration 4 must not be accepted or re-sample operands.
    dividend = 8'd50;
    divisor  = 8'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    wait_done(n, bn, to);
    checks++;
    if (to || (n + 5) !== 8) begin
      errors++;
      $display("FAIL ignore_latency: got %0d (timeout=%0b), expected 8", n + 5, to);
    end
    e = pop_expected();
    o = observed();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL ignore_result: got q=%0d r=%0d dbz=%0b, expected q=%0d r=%0d dbz=%0b",
               o.quo, o.rem, o.dbz, e.quo, e.rem, e.dbz);
    end
    // Start in the done cycle is accepted immediately.
    issue(8'd50, 8'd3);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%0b done=%0b, expected busy=1 done=0", busy, done);
    end
    wait_done(n, bn, to);
    checks++;
    if (to || n !== 8) begin
      errors++;
      $display("FAIL b2b_latency: got %0d (timeout=%0b), expected 8", n, to);
    end
    e = pop_expected();
    o = observed();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL b2b_result: got q=%0d r=%0d dbz=%0b, expected q=%0d r=%0d dbz=%0b",
               o.quo, o.rem, o.dbz, e.quo, e.rem, e.dbz);
    end
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() !== 0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got pending=%0d done=%0b busy=%0b, expected 0 0 0",
               exp_q.size(), done, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int n, bn, done_seen;
    bit to;
    result_t e, o;
    issue(8'd123, 8'd11);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
      errors++;
      $display("FAIL midrun_reset_outputs: got busy=%0b done=%0b q=%0d r=%0d dbz=%0b, expected all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    done_seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("FAIL midrun_no_done: got %0d done pulses, expected 0", done_seen);
    end
    issue(8'd123, 8'd11);
    wait_done(n, bn, to);
    checks++;
    if (to || n !== 8) begin
      errors++;
      $display("FAIL midrun_retry_latency: got %0d (timeout=%0b), expected 8", n, to);
    end
    e = pop_expected();
    o = observed();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL midrun_retry_result: got q=%0d r=%0d dbz=%0b, expected q=%0d r=%0d dbz=%0b",
               o.quo, o.rem, o.dbz, e.quo, e.rem, e.dbz);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int n, bn;
    bit to;
    logic [7:0] a, b;
    result_t e, o;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      issue(a, b);
      wait_done(n, bn, to);
      checks++;
      if (to || n !== 8) begin
        errors++;
        $display("FAIL rand_latency[%0d]: got %0d (timeout=%0b), expected 8", i, n, to);
      end
      e = pop_expected();
      o = observed();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rand_result[%0d] %0d/%0d: got q=%0d r=%0d, expected q=%0d r=%0d",
                 i, a, b, o.quo, o.rem, e.quo, e.rem);
      end
      checks++;
      if ((int'(quotient) * int'(b) + int'(remainder)) !== int'(a) || remainder >= b) begin
        errors++;
        $display("FAIL rand_invariant[%0d] %0d/%0d: got q=%0d r=%0d, expected q*d+r=%0d with r<d",
                 i, a, b, quotient, remainder, a);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    test_reset();
    test_basic();
    test_boundary();
    test_div_zero();
    test_ignore_and_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
